// File: rtl/sseg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_mux
// Description : Multiplexed seven-segment driver with double-buffered load,
//               per-digit blank/blink/dp control and leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_mux #(
    parameter int DIGITS       = 4,
    parameter int SCAN_CYCLES  = 65000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   hex_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     blink_in,
    input  logic                  lz_en,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            sseg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int c_IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_SLOT_W = $clog2(SCAN_CYCLES);
    localparam int c_FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [4*DIGITS-1:0] r_hex_q, w_hex_d;
    logic [DIGITS-1:0]   r_dp_q, w_dp_d;
    logic [DIGITS-1:0]   r_blank_q, w_blank_d;
    logic [DIGITS-1:0]   r_blink_q, w_blink_d;
    logic [c_IDX_W-1:0]  r_idx_q, w_idx_d;
    logic [c_SLOT_W-1:0] r_slot_q, w_slot_d;
    logic [c_FRM_W-1:0]  r_frame_q, w_frame_d;
    logic                r_phase_q, w_phase_d;
    logic                r_wrap_q, w_wrap_d;
    logic [DIGITS-1:0]   r_an_q, w_an_d;
    logic [6:0]          r_sseg_q, w_sseg_d;
    logic                r_dpo_q, w_dpo_d;
    logic                r_fd_q, w_fd_d;

    logic                w_slot_last, w_idx_last, w_frame_last;
    logic [DIGITS-1:0]   w_lz_dark;
    logic                w_run;
    logic                w_dark;
    logic [3:0]          w_nib;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        case (nib)
            4'h0: f_decode = 7'b1000000;
            4'h1: f_decode = 7'b1111001;
            4'h2: f_decode = 7'b0100100;
            4'h3: f_decode = 7'b0110000;
            4'h4: f_decode = 7'b0011001;
            4'h5: f_decode = 7'b0010010;
            4'h6: f_decode = 7'b0000010;
            4'h7: f_decode = 7'b1111000;
            4'h8: f_decode = 7'b0000000;
            4'h9: f_decode = 7'b0010000;
            4'hA: f_decode = 7'b0001000;
            4'hB: f_decode = 7'b0000011;
            4'hC: f_decode = 7'b1000110;
            4'hD: f_decode = 7'b0100001;
            4'hE: f_decode = 7'b0000110;
            default: f_decode = 7'b0001110;
        endcase
    endfunction

    assign w_slot_last  = (r_slot_q  == c_SLOT_W'(SCAN_CYCLES - 1));
    assign w_idx_last   = (r_idx_q   == c_IDX_W'(DIGITS - 1));
    assign w_frame_last = (r_frame_q == c_FRM_W'(BLINK_FRAMES - 1));

    always_comb begin
        w_hex_d   = load ? hex_in   : r_hex_q;
        w_dp_d    = load ? dp_in    : r_dp_q;
        w_blank_d = load ? blank_in : r_blank_q;
        w_blink_d = load ? blink_in : r_blink_q;
    end

    always_comb begin
        w_slot_d  = r_slot_q;
        w_idx_d   = r_idx_q;
        w_frame_d = r_frame_q;
        w_phase_d = r_phase_q;
        w_wrap_d  = 1'b0;
        if (w_slot_last) begin
            w_slot_d = '0;
            if (w_idx_last) begin
                w_idx_d  = '0;
                w_wrap_d = 1'b1;
                if (w_frame_last) begin
                    w_frame_d = '0;
                    w_phase_d = ~r_phase_q;
                end else begin
                    w_frame_d = r_frame_q + 1'b1;
                end
            end else begin
                w_idx_d = r_idx_q + 1'b1;
            end
        end else begin
            w_slot_d = r_slot_q + 1'b1;
        end
    end

    // Walk from the most significant digit down; a digit is suppressed while
    // every digit from it upward is zero. Digit 0 is never suppressed.
    always_comb begin
        w_lz_dark = '0;
        w_run     = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_run        = w_run & (r_hex_q[4*i +: 4] == 4'h0);
            w_lz_dark[i] = w_run & lz_en;
        end
    end

    always_comb begin
        w_nib   = r_hex_q[{r_idx_q, 2'b00} +: 4];
        w_dark  = r_blank_q[r_idx_q] | (r_blink_q[r_idx_q] & r_phase_q) | w_lz_dark[r_idx_q];
        w_an_d  = '1;
        w_an_d[r_idx_q] = 1'b0;
        w_sseg_d = w_dark ? 7'h7F : f_decode(w_nib);
        w_dpo_d  = w_dark ? 1'b1  : ~r_dp_q[r_idx_q];
        // Delayed one cycle so the strobe lines up with an returning to digit 0.
        w_fd_d   = r_wrap_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hex_q   <= '0;
            r_dp_q    <= '0;
            r_blank_q <= '0;
            r_blink_q <= '0;
            r_idx_q   <= '0;
            r_slot_q  <= '0;
            r_frame_q <= '0;
            r_phase_q <= 1'b0;
            r_wrap_q  <= 1'b0;
            r_an_q    <= '1;
            r_sseg_q  <= 7'h7F;
            r_dpo_q   <= 1'b1;
            r_fd_q    <= 1'b0;
        end else begin
            r_hex_q   <= w_hex_d;
            r_dp_q    <= w_dp_d;
            r_blank_q <= w_blank_d;
            r_blink_q <= w_blink_d;
            r_idx_q   <= w_idx_d;
            r_slot_q  <= w_slot_d;
            r_frame_q <= w_frame_d;
            r_phase_q <= w_phase_d;
            r_wrap_q  <= w_wrap_d;
            r_an_q    <= w_an_d;
            r_sseg_q  <= w_sseg_d;
            r_dpo_q   <= w_dpo_d;
            r_fd_q    <= w_fd_d;
        end
    end

    assign an         = r_an_q;
    assign sseg       = r_sseg_q;
    assign dp         = r_dpo_q;
    assign frame_done = r_fd_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_scan_mux
// Description : Directed self-checking bench for sseg_scan_mux (4 digits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_mux;

    localparam int DIGITS       = 4;
    localparam int SCAN_CYCLES  = 4;
    localparam int BLINK_FRAMES = 2;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  blink_in;
    logic        lz_en;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dpv;
        logic [3:0]  blank;
        logic        lz;
        logic        ld;
        int          dig;
        logic [6:0]  exp_sseg;
        logic        exp_dp;
    } vec_t;

    vec_t vq[$];

    sseg_scan_mux #(
        .DIGITS       (DIGITS),
        .SCAN_CYCLES  (SCAN_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .blink_in   (blink_in),
        .lz_en      (lz_en),
        .an         (an),
        .sseg       (sseg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_an(input logic [3:0] pat, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (an === pat) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_an: an never reached %b", pat);
        end
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_fd: frame_done never pulsed");
        end
    endtask

    task automatic add(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b,
                       input logic z, input logic l, input int g,
                       input logic [6:0] s, input logic p);
        vec_t v;
        v.hex = h; v.dpv = d; v.blank = b; v.lz = z; v.ld = l;
        v.dig = g; v.exp_sseg = s; v.exp_dp = p;
        vq.push_back(v);
    endtask

    initial begin
        bit          ok;
        int          n;
        logic [3:0]  pat;
        bit          lit [8];
        int          lit_cnt;
        bit          bad;

        //   hex      dp       blank    lz  ld  dig sseg    dp
        add(16'h3A9F, 4'b0100, 4'b0000, 0,  1,  0,  7'h0E, 1);
        add(16'h3A9F, 4'b0100, 4'b0000, 0,  1,  1,  7'h10, 1);
        add(16'h3A9F, 4'b0100, 4'b0000, 0,  1,  2,  7'h08, 0);
        add(16'h3A9F, 4'b0100, 4'b0000, 0,  1,  3,  7'h30, 1);
        add(16'hFFFF, 4'b0000, 4'b1111, 0,  0,  1,  7'h10, 1);
        add(16'h0050, 4'b0000, 4'b0000, 1,  1,  3,  7'h7F, 1);
        add(16'h0050, 4'b0000, 4'b0000, 1,  1,  2,  7'h7F, 1);
        add(16'h0050, 4'b0000, 4'b0000, 1,  1,  1,  7'h12, 1);
        add(16'h0050, 4'b0000, 4'b0000, 1,  1,  0,  7'h40, 1);
        add(16'h0050, 4'b0000, 4'b0000, 0,  0,  3,  7'h40, 1);
        add(16'h0000, 4'b0000, 4'b0000, 1,  1,  0,  7'h40, 1);
        add(16'h0000, 4'b0000, 4'b0000, 1,  1,  1,  7'h7F, 1);
        add(16'h0000, 4'b0000, 4'b0001, 1,  1,  0,  7'h7F, 1);
        add(16'h0050, 4'b1111, 4'b0000, 1,  1,  3,  7'h7F, 1);
        add(16'h0050, 4'b1111, 4'b0000, 1,  1,  1,  7'h12, 0);
        add(16'h1234, 4'b0000, 4'b0100, 0,  1,  2,  7'h7F, 1);
        add(16'h1234, 4'b0000, 4'b0100, 0,  1,  3,  7'h79, 1);
        add(16'h1234, 4'b0000, 4'b0100, 0,  1,  0,  7'h19, 1);
        add(16'h0C0D, 4'b0000, 4'b0000, 1,  1,  1,  7'h40, 1);
        add(16'h0C0D, 4'b0000, 4'b0000, 1,  1,  2,  7'h46, 1);
        add(16'h0C0D, 4'b0000, 4'b0000, 1,  1,  0,  7'h21, 1);
        add(16'h8765, 4'b0000, 4'b0000, 0,  1,  3,  7'h00, 1);
        add(16'h8765, 4'b0000, 4'b0000, 0,  1,  2,  7'h78, 1);
        add(16'h8765, 4'b0000, 4'b0000, 0,  1,  1,  7'h02, 1);
        add(16'hE000, 4'b0000, 4'b0000, 1,  1,  1,  7'h40, 1);
        add(16'hE000, 4'b0000, 4'b0000, 1,  1,  3,  7'h06, 1);

        rst = 1'b1; load = 1'b0; hex_in = '0; dp_in = '0;
        blank_in = '0; blink_in = '0; lz_en = 1'b0;

        // Reset values, then the free-running scan with zeroed shadows.
        repeat (3) @(negedge clk);
        chk("rst_an", an, 4'b1111);
        chk("rst_sseg", sseg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_fd", frame_done, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            pat = 4'b1111;
            pat[k/4] = 1'b0;
            chk($sformatf("scan_an[%0d]", k), an, pat);
            chk($sformatf("scan_sseg[%0d]", k), sseg, 7'h40);
            chk($sformatf("scan_fd[%0d]", k), frame_done, 1'b0);
        end

        // Frame strobe spacing, width and alignment with digit 0.
        wait_fd(ok);
        if (ok) begin
            chk("fd_an", an, 4'b1110);
            @(negedge clk);
            n = 1;
            chk("fd_width", frame_done, 1'b0);
            while (frame_done !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("fd_period", n, 16);
            chk("fd_an2", an, 4'b1110);
        end

        // Table of static display patterns.
        foreach (vq[i]) begin
            hex_in = vq[i].hex; dp_in = vq[i].dpv; blank_in = vq[i].blank;
            blink_in = 4'b0000; lz_en = vq[i].lz;
            if (vq[i].ld) begin
                load = 1'b1;
                @(negedge clk);
                load = 1'b0;
            end else begin
                @(negedge clk);
            end
            pat = 4'b1111;
            pat[vq[i].dig] = 1'b0;
            wait_an(pat, ok);
            if (ok) begin
                chk($sformatf("vec%0d_sseg", i), sseg, vq[i].exp_sseg);
                chk($sformatf("vec%0d_dp", i), dp, vq[i].exp_dp);
            end
        end

        // Blink on digit 0: two frames lit, two frames dark, digit 1 steady.
        hex_in = 16'h0000; dp_in = '0; blank_in = '0; blink_in = 4'b0001; lz_en = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        lit_cnt = 0;
        for (int f = 0; f < 8; f++) begin
            wait_fd(ok);
            lit[f] = (sseg == 7'h40);
            if (lit[f]) lit_cnt++;
            repeat (4) @(negedge clk);
            chk($sformatf("blink_d1[%0d]", f), sseg, 7'h40);
        end
        bad = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (lit[j] != lit[j+1] && lit[j+1] != lit[j+2]) bad = 1'b1;
            if (lit[j] == lit[j+1] && lit[j+1] == lit[j+2]) bad = 1'b1;
        end
        chk("blink_runs", bad, 1'b0);
        chk("blink_lit_frames", lit_cnt, 4);

        // Load landing on the same edge as the frame wrap.
        hex_in = 16'h1111; blink_in = '0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fd(ok);
        if (ok) begin
            repeat (14) @(negedge clk);
            hex_in = 16'h0007;
            load = 1'b1;
            @(posedge clk);
            @(negedge clk);
            load = 1'b0;
            chk("race_pre_an", an, 4'b0111);
            chk("race_pre_sseg", sseg, 7'h79);
            @(negedge clk);
            chk("race_fd", frame_done, 1'b1);
            chk("race_an", an, 4'b1110);
            chk("race_sseg", sseg, 7'h78);
        end

        // Asynchronous reset in the middle of digit 2's slot.
        wait_an(4'b1011, ok);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_an", an, 4'b1111);
        chk("arst_sseg", sseg, 7'h7F);
        chk("arst_dp", dp, 1'b1);
        chk("arst_fd", frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("arst_resume_an", an, 4'b1110);
        chk("arst_resume_sseg", sseg, 7'h40);
        @(negedge clk);
        chk("arst_next_an", an, 4'b1101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
